// File: rtl/ex_mul_unit.sv
// EX-stage iterative shift-add multiplier owning HI/LO, with MTHI/MTLO writes and pipeline stall.
// Define SIGNED_MULT_EN to make MULT (funct 6'h18) signed; otherwise MULT and MULTU are both unsigned.
module ex_mul_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mf_req,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] FunctMult  = 6'h18;
  localparam logic [5:0] FunctMultu = 6'h19;

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 start_ok;
  logic                 last_iter;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   product;

  assign start_ok  = start & ((funct == FunctMult) | (funct == FunctMultu));
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef SIGNED_MULT_EN
  logic is_signed;
  logic sign_neg_q, sign_neg_d;

  assign is_signed = (funct == FunctMult);

  // Multiply magnitudes; the most-negative operand's magnitude still fits as unsigned.
  always_comb begin
    mag_a      = (is_signed & op_a[WIDTH-1]) ? (~op_a + WIDTH'(1)) : op_a;
    mag_b      = (is_signed & op_b[WIDTH-1]) ? (~op_b + WIDTH'(1)) : op_b;
    sign_neg_d = sign_neg_q;
    if (state_q == StIdle && start_ok) begin
      sign_neg_d = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
    end
    product = sign_neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sign_neg_q <= 1'b0;
    end else begin
      sign_neg_q <= sign_neg_d;
    end
  end
`else
  always_comb begin
    mag_a   = op_a;
    mag_b   = op_b;
    product = acc_q;
  end
`endif

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_ok) state_d = StRun;
      StRun:   if (last_iter) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: operand capture, add/shift iterations, HI/LO updates.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (mplier_q[0] ? mcand_q : '0)};
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          // A coinciding MTHI/MTLO is dropped; start takes priority.
          mcand_d  = mag_a;
          mplier_d = mag_b;
          acc_d    = '0;
          cnt_d    = '0;
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      StRun: begin
        acc_d    = {sum, acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
      end
      StFin: begin
        hi_d = product[2*WIDTH-1:WIDTH];
        lo_d = product[WIDTH-1:0];
      end
      default: ;
    endcase
    busy_d = (state_d != StIdle);
    done_d = (state_q == StFin);
  end

  // Outputs.
  always_comb begin
    busy  = busy_q;
    done  = done_q;
    hi    = hi_q;
    lo    = lo_q;
    stall = busy_q & (start | mf_req | hi_we | lo_we);
  end

endmodule
